// File: rtl/led_seq_checker.sv
// Watches a 16-bit LED bus and tracks the expected up/down/kickback/blink
// sequence; reports the inferred phase, kickbacks and violations.
module led_seq_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flick,
  input  logic [15:0]      leds,
  output logic [3:0]       phase,
  output logic [4:0]       level,
  output logic             seq_done,
  output logic             kick,
  output logic [CNT_W-1:0] kick_cnt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int unsigned LED_W = 16;
  localparam int unsigned L_W   = 5;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    UP_A   = 4'd1,
    DOWN_A = 4'd2,
    UP_B   = 4'd3,
    DOWN_B = 4'd4,
    UP_C   = 4'd5,
    DOWN_C = 4'd6,
    BLINK  = 4'd7,
    HUNT   = 4'd8
  } phase_t;

  phase_t         state_q, state_d, hit_state;
  logic           flick_q;
  logic [L_W-1:0] pop_c, exp_c;
  logic           therm_c, check_c, spur_c, kick_c, done_c, err_c, kick_ok_c;
  logic [1:0]     code_c;

  // Popcount and thermometer test of the current sample
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < LED_W; i++) pop_c = pop_c + L_W'(leds[i]);
    therm_c = ((leds & (leds + 16'd1)) == 16'd0);
  end

  // level doubles as L_prev; kickback is legal only at 6 or 11 with flick held
  assign kick_ok_c = flick_q && (level == 5'd6 || level == 5'd11);

  // Expected level, phase on a clean sample, and the resulting violation code
  always_comb begin
    exp_c     = '0;
    hit_state = state_q;
    check_c   = 1'b1;
    spur_c    = 1'b0;
    kick_c    = 1'b0;
    done_c    = 1'b0;
    code_c    = 2'd0;
    unique case (state_q)
      IDLE: begin
        if (flick_q) begin
          exp_c     = 5'd1;
          hit_state = UP_A;
        end else begin
          spur_c = (pop_c != 5'd0);
        end
      end
      UP_A: begin
        if (level < 5'd6) exp_c = level + 5'd1;
        else begin
          exp_c     = 5'd5;
          hit_state = DOWN_A;
        end
      end
      DOWN_A: begin
        if (level > 5'd0) exp_c = level - 5'd1;
        else begin
          exp_c     = 5'd1;
          hit_state = UP_B;
        end
      end
      UP_B: begin
        if (kick_ok_c) begin
          exp_c     = level - 5'd1;
          hit_state = DOWN_A;
          kick_c    = 1'b1;
        end else if (level < 5'd11) exp_c = level + 5'd1;
        else begin
          exp_c     = 5'd10;
          hit_state = DOWN_B;
        end
      end
      DOWN_B: begin
        if (level > 5'd5) exp_c = level - 5'd1;
        else begin
          exp_c     = 5'd6;
          hit_state = UP_C;
        end
      end
      UP_C: begin
        if (kick_ok_c) begin
          exp_c     = level - 5'd1;
          hit_state = DOWN_B;
          kick_c    = 1'b1;
        end else if (level < 5'd16) exp_c = level + 5'd1;
        else begin
          exp_c     = 5'd15;
          hit_state = DOWN_C;
        end
      end
      DOWN_C: begin
        if (level > 5'd0) exp_c = level - 5'd1;
        else begin
          exp_c     = 5'd16;
          hit_state = BLINK;
        end
      end
      BLINK: begin
        hit_state = IDLE;
        done_c    = 1'b1;
      end
      HUNT: begin
        check_c   = 1'b0;
        hit_state = (pop_c == 5'd0) ? IDLE : HUNT;
      end
      default: begin
        check_c   = 1'b0;
        hit_state = IDLE;
      end
    endcase
    if (check_c) begin
      if (!therm_c)             code_c = 2'd1;
      else if (spur_c)          code_c = 2'd3;
      else if (pop_c != exp_c)  code_c = 2'd2;
    end
    err_c   = (code_c != 2'd0);
    state_d = err_c ? HUNT : hit_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      flick_q  <= 1'b0;
      level    <= '0;
      seq_done <= 1'b0;
      kick     <= 1'b0;
      kick_cnt <= '0;
      err      <= 1'b0;
      err_code <= '0;
      err_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      flick_q  <= flick;
      level    <= pop_c;
      seq_done <= done_c & ~err_c;
      kick     <= kick_c & ~err_c;
      err      <= err_c;
      if (kick_c && !err_c && kick_cnt != '1) kick_cnt <= kick_cnt + CNT_W'(1);
      if (err_c) begin
        err_code <= code_c;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_led_seq_checker.sv
// Self-checking bench for led_seq_checker: table-driven sequence model,
// directed scenarios and randomized LED traffic.
module tb_led_seq_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flick = 1'b0;
  logic [15:0] leds = 16'h0;
  logic [3:0]  phase;
  logic [4:0]  level;
  logic        seq_done, kick, err;
  logic [7:0]  kick_cnt, err_cnt;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errors = 0;

  led_seq_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flick(flick), .leds(leds),
    .phase(phase), .level(level), .seq_done(seq_done), .kick(kick),
    .kick_cnt(kick_cnt), .err(err), .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Ramp phases 1..6 described as direction plus turning point
  int step_tab [0:6] = '{0, 1, -1, 1, -1, 1, -1};
  int turn_at  [0:6] = '{0, 6, 0, 11, 5, 16, 0};
  int turn_to  [0:6] = '{0, 5, 1, 10, 6, 15, 16};

  int m_phase, m_level, m_kcnt, m_ecnt, m_code;
  bit m_fprev, m_done, m_kick, m_err;

  function automatic logic [15:0] therm(input int l);
    logic [31:0] v;
    v = (32'd1 << l) - 32'd1;
    return v[15:0];
  endfunction

  function automatic void rules(input int ph, input int lp, input bit fp,
                                output int ex, output int nx, output bit kk, output bit dn);
    kk = 0; dn = 0; ex = 0; nx = ph;
    if (ph == 0) begin
      ex = fp ? 1 : 0; nx = fp ? 1 : 0;
    end else if (ph == 7) begin
      ex = 0; nx = 0; dn = 1;
    end else if ((ph == 3 || ph == 5) && fp && (lp == 6 || lp == 11)) begin
      ex = lp - 1; nx = ph - 1; kk = 1;
    end else if (lp == turn_at[ph]) begin
      ex = turn_to[ph]; nx = ph + 1;
    end else begin
      ex = lp + step_tab[ph];
    end
  endfunction

  task automatic model_reset();
    m_phase = 0; m_level = 0; m_kcnt = 0; m_ecnt = 0; m_code = 0;
    m_fprev = 0; m_done = 0; m_kick = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [15:0] lv, input bit fl);
    int l, ex, nx, code;
    bit kk, dn;
    l = $countones(lv);
    m_err = 0; m_kick = 0; m_done = 0;
    if (m_phase == 8) begin
      m_phase = (l == 0) ? 0 : 8;
    end else begin
      rules(m_phase, m_level, m_fprev, ex, nx, kk, dn);
      if (lv != therm(l))                      code = 1;
      else if (m_phase == 0 && !m_fprev && l != 0) code = 3;
      else if (l != ex)                        code = 2;
      else                                     code = 0;
      if (code != 0) begin
        m_err = 1; m_code = code; m_phase = 8;
        if (m_ecnt < 255) m_ecnt++;
      end else begin
        m_phase = nx; m_kick = kk; m_done = dn;
        if (kk && m_kcnt < 255) m_kcnt++;
      end
    end
    m_level = l; m_fprev = fl;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("phase", int'(phase), m_phase);
    chk("level", int'(level), m_level);
    chk("seq_done", int'(seq_done), int'(m_done));
    chk("kick", int'(kick), int'(m_kick));
    chk("kick_cnt", int'(kick_cnt), m_kcnt);
    chk("err", int'(err), int'(m_err));
    chk("err_code", int'(err_code), m_code);
    chk("err_cnt", int'(err_cnt), m_ecnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_outs"}, int'({seq_done, kick, err, err_code}), 0);
    chk({tag, "_cnts"}, int'({kick_cnt, err_cnt}), 0);
  endtask

  task automatic drive(input logic [15:0] lv, input bit fl);
    @(negedge clk);
    leds = lv; flick = fl;
    @(posedge clk);
    #1;
    model_step(lv, fl);
    check_all();
  endtask

  task automatic ramp(input int a, input int b);
    int s;
    s = (b >= a) ? 1 : -1;
    for (int l = a; l != b + s; l += s) drive(therm(l), 1'b0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; leds = 16'h0; flick = 1'b0;
    model_reset();
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int ex, nx, r;
    bit kk, dn;
    logic [15:0] lv;
    bit fl;

    model_reset();
    #1 check_zero("por");
    reset_dut();

    // Full legal sequence with a phase check at each turning point
    drive(16'h0, 1'b1);     chk("gold_idle", int'(phase), 0);
    ramp(1, 6);             chk("gold_up_a", int'(phase), 1);
    ramp(5, 0);             chk("gold_down_a", int'(phase), 2);
    ramp(1, 11);            chk("gold_up_b", int'(phase), 3);
    ramp(10, 5);            chk("gold_down_b", int'(phase), 4);
    ramp(6, 16);            chk("gold_up_c", int'(phase), 5);
    ramp(15, 0);            chk("gold_down_c", int'(phase), 6);
    drive(16'hFFFF, 1'b0);  chk("gold_blink", int'(phase), 7);
    drive(16'h0000, 1'b0);
    chk("gold_done", int'(seq_done), 1);
    chk("gold_end_phase", int'(phase), 0);
    chk("gold_no_err", int'(err_cnt), 0);

    // Kickback in UP_B at L=11
    reset_dut();
    drive(16'h0, 1'b1); ramp(1, 6); ramp(5, 0); ramp(1, 10);
    drive(16'h07FF, 1'b1);
    drive(16'h03FF, 1'b0);
    chk("kick_pulse", int'(kick), 1);
    chk("kick_cnt1", int'(kick_cnt), 1);
    chk("kick_phase", int'(phase), 2);
    chk("kick_no_err", int'(err), 0);

    // Non-thermometer glitch in UP_A
    reset_dut();
    drive(16'h0, 1'b1); drive(16'h0001, 1'b0); drive(16'h0003, 1'b0);
    drive(16'h0005, 1'b0);
    chk("glitch_err", int'(err), 1);
    chk("glitch_code", int'(err_code), 1);
    chk("glitch_cnt", int'(err_cnt), 1);
    chk("glitch_phase", int'(phase), 8);
    chk("glitch_level", int'(level), 2);
    drive(16'h0000, 1'b0);
    chk("hunt_exit", int'(phase), 0);

    // Skip from 3 to 5
    reset_dut();
    drive(16'h0, 1'b1); ramp(1, 3); drive(therm(5), 1'b0);
    chk("skip_code", int'(err_code), 2);
    chk("skip_phase", int'(phase), 8);

    // Spurious start
    reset_dut();
    drive(16'h0, 1'b0); drive(16'h0001, 1'b0);
    chk("spur_code", int'(err_code), 3);

    // Randomized traffic, mostly following the legal sequence
    reset_dut();
    for (int i = 0; i < 4000; i++) begin
      if (m_phase == 8) ex = ($urandom % 2 == 0) ? 0 : int'($urandom % 17);
      else rules(m_phase, m_level, m_fprev, ex, nx, kk, dn);
      if (ex < 0 || ex > 16) ex = 0;
      r = int'($urandom % 100);
      if (r < 97)      lv = therm(ex);
      else if (r < 99) lv = therm(int'($urandom % 17));
      else             lv = 16'($urandom);
      if (m_phase == 0) fl = ($urandom % 3 == 0);
      else if ($countones(lv) == 6 || $countones(lv) == 11) fl = ($urandom % 4 == 0);
      else fl = ($urandom % 16 == 0);
      drive(lv, fl);
    end

    // Error counter saturation
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      drive(16'h0001, 1'b0);
      drive(16'h0000, 1'b0);
    end
    chk("sat_err_cnt", int'(err_cnt), 255);
    chk("sat_err_code", int'(err_code), 3);

    // Asynchronous reset mid-UP_C, then IDLE rules on the first sample
    reset_dut();
    drive(16'h0, 1'b1); ramp(1, 6); ramp(5, 0); ramp(1, 11); ramp(10, 5); ramp(6, 12);
    chk("pre_reset_phase", int'(phase), 5);
    #2 rst = 1'b0;
    model_reset();
    #1 check_zero("async");
    @(negedge clk);
    leds = 16'h0; flick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(16'h0001, 1'b0);
    chk("post_reset_code", int'(err_code), 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
